// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: quadrant pre-rotation on accept, N_ITER shift-add
// micro-rotations on one adder stage, optional gain compensation, then hold until taken.
module cordic_iter_ctrl #(
    parameter int CORDIC_WIDTH = 22,
    parameter int N_ITER       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           mode,
    input  logic                           scale_en,
    input  logic signed [CORDIC_WIDTH-1:0] x_in,
    input  logic signed [CORDIC_WIDTH-1:0] y_in,
    input  logic signed [CORDIC_WIDTH-1:0] z_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [CORDIC_WIDTH-1:0] x_out,
    output logic signed [CORDIC_WIDTH-1:0] y_out,
    output logic signed [CORDIC_WIDTH-1:0] z_out
);

    localparam int  W     = CORDIC_WIDTH;
    localparam int  CNT_W = $clog2(N_ITER);
    localparam real PI    = 3.14159265358979323846;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_DONE} state_t;

    // Binary angle of atan(2^-i): full scale 2^(W-1) corresponds to pi.
    function automatic logic signed [W-1:0] atan_const(input int i);
        real a;
        a = $atan(1.0 / (2.0 ** i)) * (2.0 ** (W - 1)) / PI;
        return W'($rtoi(a + 0.5));
    endfunction

    // Shift-add approximation of 1/K (~0.60724); each term truncates toward -inf.
    function automatic logic signed [W-1:0] gain_comp(input logic signed [W-1:0] v);
        return (v >>> 1) + (v >>> 4) + (v >>> 5) + (v >>> 7) + (v >>> 8)
             + (v >>> 10) + (v >>> 11) + (v >>> 12) + (v >>> 14);
    endfunction

    logic signed [W-1:0] atan_tbl [N_ITER];

    for (genvar g = 0; g < N_ITER; g++) begin : g_atan
        localparam logic signed [W-1:0] ATAN_G = atan_const(g);
        assign atan_tbl[g] = ATAN_G;
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic                mode_q, mode_d;
    logic                scale_en_q, scale_en_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;

    logic                d_pos;
    logic signed [W-1:0] x_sh, y_sh;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        mode_d      = mode_q;
        scale_en_d  = scale_en_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        d_pos = mode_q ? y_q[W-1] : ~z_q[W-1];
        x_sh  = x_q >>> cnt_q;
        y_sh  = y_q >>> cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = S_ITER;
                    in_ready_d = 1'b0;
                    cnt_d      = '0;
                    mode_d     = mode;
                    scale_en_d = scale_en;
                    x_d        = x_in;
                    y_d        = y_in;
                    z_d        = z_in;
                    // Fold the operand into the +/-pi/2 convergence range by a pi rotation.
                    if (!mode) begin
                        if (z_in[W-1] != z_in[W-2]) begin
                            x_d = -x_in;
                            y_d = -y_in;
                            z_d = {~z_in[W-1], z_in[W-2:0]};
                        end
                    end else if (x_in[W-1]) begin
                        x_d = -x_in;
                        y_d = -y_in;
                        z_d = {1'b1, {(W-1){1'b0}}};
                    end else begin
                        z_d = '0;
                    end
                end
            end
            S_ITER: begin
                if (d_pos) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_tbl[cnt_q];
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_tbl[cnt_q];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                if (scale_en_q) begin
                    x_d = gain_comp(x_q);
                    y_d = gain_comp(y_q);
                end
                state_d     = S_DONE;
                out_valid_d = 1'b1;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            mode_q      <= 1'b0;
            scale_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            mode_q      <= mode_d;
            scale_en_q  <= scale_en_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;

endmodule
